pmod_debounce: RTL and testbench

//   Synchronises and debounces the active-low PMOD push-button inputs before they

---
 rtl/pmod_debounce_pkg.sv | 22 ++
 rtl/debounce_chan.sv | 73 +++++++
 rtl/pmod_debounce.sv | 49 ++++
 tb/tb_pmod_debounce.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pmod_debounce_pkg.sv
// ---------------------------------------------------------------------------
// pmod_debounce_pkg
//   Shared constants for the PMOD push-button front end.
//   PMOD_IDLE_LEVEL            : released level of an active-low button (1)
//   PMOD_WIDTH                 : number of button channels on the PMOD header
//   PMOD_DEBOUNCE_CYCLES_12MHZ : 10 ms settle window at 12 MHz
//   PMOD_SYNC_STAGES           : synchroniser depth for the asynchronous pins
//   cnt_width()                : width of a counter that must reach n-1
// ---------------------------------------------------------------------------
package pmod_debounce_pkg;

    localparam logic PMOD_IDLE_LEVEL            = 1'b1;
    localparam int   PMOD_WIDTH                 = 3;
    localparam int   PMOD_DEBOUNCE_CYCLES_12MHZ = 120000;
    localparam int   PMOD_SYNC_STAGES           = 2;

    // Enough bits to hold 0 .. n-1; never below one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// ---------------------------------------------------------------------------
// debounce_chan
//   One button channel: multi-flop synchroniser, stability counter,
//   registered debounced level and one-cycle transition strobes.
//   Optional feature macro: PMOD_DEBOUNCE_RELEASE_PULSE_EN adds release_pulse.
// Ports
//   clk           : system clock
//   rst_n         : asynchronous active-low reset
//   raw           : raw active-low pin level, asynchronous to clk
//   db            : debounced level, active-low, registered
//   press_pulse   : one-cycle strobe on an accepted 1->0 transition
//   release_pulse : one-cycle strobe on an accepted 0->1 transition (macro only)
// ---------------------------------------------------------------------------
module debounce_chan
    import pmod_debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = PMOD_SYNC_STAGES,
    parameter int STABLE_CYCLES = PMOD_DEBOUNCE_CYCLES_12MHZ
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db,
    output logic press_pulse
`ifdef PMOD_DEBOUNCE_RELEASE_PULSE_EN
    ,
    output logic release_pulse
`endif
);

    localparam int              CNT_W    = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   sync;

    assign sync = sync_q[SYNC_STAGES-1];

    // The counter only runs while the synchronised input disagrees with the
    // accepted level; agreement (including a bounce back) clears it, and
    // reaching CNT_LAST accepts the new level and clears it, so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= {SYNC_STAGES{PMOD_IDLE_LEVEL}};
            db          <= PMOD_IDLE_LEVEL;
            cnt         <= '0;
            press_pulse <= 1'b0;
`ifdef PMOD_DEBOUNCE_RELEASE_PULSE_EN
            release_pulse <= 1'b0;
`endif
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], raw};
            press_pulse <= 1'b0;
`ifdef PMOD_DEBOUNCE_RELEASE_PULSE_EN
            release_pulse <= 1'b0;
`endif
            if (sync == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db          <= sync;
                cnt         <= '0;
                press_pulse <= ~sync;
`ifdef PMOD_DEBOUNCE_RELEASE_PULSE_EN
                release_pulse <= sync;
`endif
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pmod_debounce.sv
// ---------------------------------------------------------------------------
// pmod_debounce
//   Synchronises and debounces the active-low PMOD push buttons. Outputs keep
//   the active-low polarity so the adder logic uses pmod_db directly.
//   Optional feature macro: PMOD_DEBOUNCE_RELEASE_PULSE_EN adds release_pulse.
// Ports
//   clk           : system clock (12 MHz on iCEstick)
//   rst_n         : asynchronous active-low reset
//   pmod_raw      : raw pin levels, active-low, asynchronous
//   pmod_db       : debounced levels, active-low, registered
//   press_pulse   : per-bit one-cycle strobe on accepted 1->0 transition
//   release_pulse : per-bit one-cycle strobe on accepted 0->1 (macro only)
// ---------------------------------------------------------------------------
module pmod_debounce
    import pmod_debounce_pkg::*;
#(
    parameter int WIDTH         = PMOD_WIDTH,
    parameter int SYNC_STAGES   = PMOD_SYNC_STAGES,
    parameter int STABLE_CYCLES = PMOD_DEBOUNCE_CYCLES_12MHZ
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pmod_raw,
    output logic [WIDTH-1:0] pmod_db,
    output logic [WIDTH-1:0] press_pulse
`ifdef PMOD_DEBOUNCE_RELEASE_PULSE_EN
    ,
    output logic [WIDTH-1:0] release_pulse
`endif
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        debounce_chan #(
            .SYNC_STAGES   (SYNC_STAGES),
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_chan (
            .clk           (clk),
            .rst_n         (rst_n),
            .raw           (pmod_raw[i]),
            .db            (pmod_db[i]),
            .press_pulse   (press_pulse[i])
`ifdef PMOD_DEBOUNCE_RELEASE_PULSE_EN
            ,
            .release_pulse (release_pulse[i])
`endif
        );
    end

endmodule

// File: tb/tb_pmod_debounce.sv
// ---------------------------------------------------------------------------
// tb_pmod_debounce
//   Directed bench for pmod_debounce with STABLE_CYCLES=8, SYNC_STAGES=2,
//   giving a 10-cycle accept latency from a clean raw edge.
// ---------------------------------------------------------------------------
module tb_pmod_debounce;

    logic       clk;
    logic       rst_n;
    logic [2:0] pmod_raw;
    logic [2:0] pmod_db;
    logic [2:0] press_pulse;
`ifdef PMOD_DEBOUNCE_RELEASE_PULSE_EN
    logic [2:0] release_pulse;
`endif

    int vectors;
    int miscompares;

    pmod_debounce #(
        .WIDTH         (3),
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pmod_raw      (pmod_raw),
        .pmod_db       (pmod_db),
        .press_pulse   (press_pulse)
`ifdef PMOD_DEBOUNCE_RELEASE_PULSE_EN
        ,
        .release_pulse (release_pulse)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge, then settle before sampling / driving.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [2:0] raw_val);
        pmod_raw = raw_val;
        rst_n    = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        pmod_raw = 3'b000;
        rst_n    = 1'b0;
        #2;
        cyc();
        cyc();
        vectors++;
        if (pmod_db !== 3'b111) begin
            miscompares++;
            $display("FAIL reset_db: got %b want %b", pmod_db, 3'b111);
        end
        vectors++;
        if (press_pulse !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_press: got %b want %b", press_pulse, 3'b000);
        end
`ifdef PMOD_DEBOUNCE_RELEASE_PULSE_EN
        vectors++;
        if (release_pulse !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_release: got %b want %b", release_pulse, 3'b000);
        end
`endif
    endtask

    task automatic test_single_press();
        apply_reset(3'b111);
        pmod_raw = 3'b110;
        for (int c = 1; c <= 9; c++) begin
            cyc();
            vectors++;
            if (pmod_db !== 3'b111 || press_pulse !== 3'b000) begin
                miscompares++;
                $display("FAIL press_wait c%0d: got db=%b pp=%b want db=111 pp=000", c, pmod_db, press_pulse);
            end
        end
        cyc();
        vectors++;
        if (pmod_db !== 3'b110 || press_pulse !== 3'b001) begin
            miscompares++;
            $display("FAIL press_accept: got db=%b pp=%b want db=110 pp=001", pmod_db, press_pulse);
        end
        cyc();
        vectors++;
        if (pmod_db !== 3'b110 || press_pulse !== 3'b000) begin
            miscompares++;
            $display("FAIL press_after: got db=%b pp=%b want db=110 pp=000", pmod_db, press_pulse);
        end
    endtask

    task automatic test_bounce();
        apply_reset(3'b111);
        pmod_raw = 3'b101;
        for (int c = 1; c <= 20; c++) begin
            cyc();
            if (c == 5) pmod_raw = 3'b111;
            vectors++;
            if (pmod_db !== 3'b111 || press_pulse !== 3'b000) begin
                miscompares++;
                $display("FAIL bounce c%0d: got db=%b pp=%b want db=111 pp=000", c, pmod_db, press_pulse);
            end
        end
    endtask

    task automatic test_simultaneous();
        apply_reset(3'b111);
        pmod_raw = 3'b000;
        for (int c = 1; c <= 9; c++) cyc();
        vectors++;
        if (pmod_db !== 3'b111) begin
            miscompares++;
            $display("FAIL simul_before: got db=%b want 111", pmod_db);
        end
        cyc();
        vectors++;
        if (pmod_db !== 3'b000 || press_pulse !== 3'b111) begin
            miscompares++;
            $display("FAIL simul_accept: got db=%b pp=%b want db=000 pp=111", pmod_db, press_pulse);
        end
        cyc();
        vectors++;
        if (press_pulse !== 3'b000) begin
            miscompares++;
            $display("FAIL simul_after: got pp=%b want 000", press_pulse);
        end
    endtask

    task automatic test_reset_mid_count();
        apply_reset(3'b111);
        pmod_raw = 3'b011;
        for (int c = 1; c <= 5; c++) cyc();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (pmod_db !== 3'b111 || press_pulse !== 3'b000) begin
            miscompares++;
            $display("FAIL midrst_async: got db=%b pp=%b want db=111 pp=000", pmod_db, press_pulse);
        end
        cyc();
        cyc();
        rst_n = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            cyc();
            vectors++;
            if (pmod_db !== 3'b111) begin
                miscompares++;
                $display("FAIL midrst_wait c%0d: got db=%b want 111", c, pmod_db);
            end
        end
        cyc();
        vectors++;
        if (pmod_db !== 3'b011 || press_pulse !== 3'b100) begin
            miscompares++;
            $display("FAIL midrst_accept: got db=%b pp=%b want db=011 pp=100", pmod_db, press_pulse);
        end
    endtask

    // Starts from pmod_db = 3'b011 left by the previous scenario.
    task automatic test_release();
        pmod_raw = 3'b111;
        for (int c = 1; c <= 9; c++) begin
            cyc();
            vectors++;
            if (pmod_db !== 3'b011) begin
                miscompares++;
                $display("FAIL release_wait c%0d: got db=%b want 011", c, pmod_db);
            end
        end
        cyc();
        vectors++;
        if (pmod_db !== 3'b111 || press_pulse !== 3'b000) begin
            miscompares++;
            $display("FAIL release_accept: got db=%b pp=%b want db=111 pp=000", pmod_db, press_pulse);
        end
`ifdef PMOD_DEBOUNCE_RELEASE_PULSE_EN
        vectors++;
        if (release_pulse !== 3'b100) begin
            miscompares++;
            $display("FAIL release_pulse: got %b want 100", release_pulse);
        end
`endif
        cyc();
`ifdef PMOD_DEBOUNCE_RELEASE_PULSE_EN
        vectors++;
        if (release_pulse !== 3'b000) begin
            miscompares++;
            $display("FAIL release_after: got %b want 000", release_pulse);
        end
`endif
        vectors++;
        if (pmod_db !== 3'b111 || press_pulse !== 3'b000) begin
            miscompares++;
            $display("FAIL release_hold: got db=%b pp=%b want db=111 pp=000", pmod_db, press_pulse);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b1;
        pmod_raw    = 3'b111;
        test_reset();
        test_single_press();
        test_bounce();
        test_simultaneous();
        test_reset_mid_count();
        test_release();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
